// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared video types: test-pattern and scheduler-state enums,
//               active-area dimensions and a bit-replication helper.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    typedef enum logic [1:0] {
        PAT_GRID  = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_WHITE = 2'd2,
        PAT_RAMP  = 2'd3
    } pattern_e;

    typedef enum logic [0:0] {
        ST_AUTO   = 1'b0,
        ST_MANUAL = 1'b1
    } sched_state_e;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Widen a single colour term to a full 4-bit channel.
    function automatic logic [3:0] rep4(input logic b);
        return {4{b}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser followed by a stability counter. The
//               synchronised level must differ from the accepted level for
//               DEBOUNCE_CYCLES consecutive cycles before it is taken; an
//               accepted 0->1 change produces a single-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse
);

    localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1_q, r_sync2_q;
    logic             r_level_q, w_level_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic             r_pulse_q, w_pulse_d;

    // Count consecutive cycles of disagreement; accept the new level at the limit.
    always_comb begin
        w_level_d = r_level_q;
        w_cnt_d   = '0;
        w_pulse_d = 1'b0;
        if (r_sync2_q != r_level_q) begin
            if (r_cnt_q == CNT_LAST) begin
                w_level_d = r_sync2_q;
                w_pulse_d = r_sync2_q;
            end else begin
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser chain and debounce state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1_q <= 1'b0;
            r_sync2_q <= 1'b0;
            r_level_q <= 1'b0;
            r_cnt_q   <= '0;
            r_pulse_q <= 1'b0;
        end else begin
            r_sync1_q <= btn_in;
            r_sync2_q <= r_sync1_q;
            r_level_q <= w_level_d;
            r_cnt_q   <= w_cnt_d;
            r_pulse_q <= w_pulse_d;
        end
    end

    assign pulse = r_pulse_q;

endmodule
`default_nettype wire

// File: rtl/pattern_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pattern_scheduler
// Description : Draws one of NUM_PATTERNS test patterns over the video sync
//               generator timing, with sync delayed to stay aligned with the
//               registered colour. Pattern advances are requested by a
//               debounced button or, with AUTO_CYCLE_EN defined, by an
//               auto-advance frame counter; they are committed only on the
//               rising edge of vsync_in.
//               Macro AUTO_CYCLE_EN: enables AUTO mode and the btn_mode toggle.
//               Without it the scheduler is fixed in MANUAL.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_scheduler
    import video_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS       = 4,
    parameter int unsigned FRAMES_PER_PATTERN = 120,
    parameter int unsigned DEBOUNCE_CYCLES    = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       display_on,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       btn_next,
    input  logic       btn_mode,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic [1:0] pattern_idx,
    output logic       auto_mode,
    output logic       frame_start
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_PATTERNS - 1);

    logic       w_next_pulse;
    logic       w_auto_req;
    logic       w_auto_mode;
    logic       w_frame_edge;
    logic       w_req;

    logic       r_vsync_prev_q;
    logic       r_hsync_q, r_vsync_q, r_frame_start_q;
    pattern_e   r_pattern_q, w_pattern_d;
    logic       r_pending_q, w_pending_d;
    logic [3:0] r_vga_r_q, w_vga_r_d;
    logic [3:0] r_vga_g_q, w_vga_g_d;
    logic [3:0] r_vga_b_q, w_vga_b_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_next_db (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_next),
        .pulse  (w_next_pulse)
    );

    assign w_frame_edge = vsync_in & ~r_vsync_prev_q;

`ifdef AUTO_CYCLE_EN
    localparam int unsigned      FCNT_W    = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_PATTERN - 1);

    logic              w_mode_pulse;
    sched_state_e      r_state_q, w_state_d;
    logic [FCNT_W-1:0] r_frame_cnt_q, w_frame_cnt_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_mode_db (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_mode),
        .pulse  (w_mode_pulse)
    );

    // Mode toggling and per-pattern frame counting; MANUAL parks the counter at 0.
    always_comb begin
        w_state_d     = r_state_q;
        w_frame_cnt_d = r_frame_cnt_q;
        w_auto_req    = 1'b0;
        if (r_state_q == ST_AUTO) begin
            if (w_mode_pulse) begin
                w_state_d     = ST_MANUAL;
                w_frame_cnt_d = '0;
            end else if (w_frame_edge) begin
                if (r_frame_cnt_q == FCNT_LAST) begin
                    w_auto_req    = 1'b1;
                    w_frame_cnt_d = '0;
                end else begin
                    w_frame_cnt_d = r_frame_cnt_q + 1'b1;
                end
            end
        end else begin
            w_frame_cnt_d = '0;
            if (w_mode_pulse) begin
                w_state_d = ST_AUTO;
            end
        end
    end

    // Scheduler state and frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= ST_AUTO;
            r_frame_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_frame_cnt_q <= w_frame_cnt_d;
        end
    end

    assign w_auto_mode = (r_state_q == ST_AUTO);
`else
    // Fixed MANUAL: the mode button and frame budget have no effect.
    logic w_unused_mode;
    assign w_unused_mode = ^{btn_mode, 32'(FRAMES_PER_PATTERN)};
    assign w_auto_req    = 1'b0;
    assign w_auto_mode   = 1'b0;
`endif

    // Requests collapse into pending; a frame edge consumes pending plus any same-cycle request.
    always_comb begin
        w_req       = w_next_pulse | w_auto_req;
        w_pattern_d = r_pattern_q;
        w_pending_d = r_pending_q | w_req;
        if (w_frame_edge) begin
            w_pending_d = 1'b0;
            if (r_pending_q | w_req) begin
                w_pattern_d = (r_pattern_q == LAST_IDX) ? PAT_GRID
                                                        : pattern_e'(r_pattern_q + 2'd1);
            end
        end
    end

    // Colour generation for the current pattern; blank outside active video.
    always_comb begin
        w_vga_r_d = 4'h0;
        w_vga_g_d = 4'h0;
        w_vga_b_d = 4'h0;
        if (display_on) begin
            case (r_pattern_q)
                PAT_GRID: begin
                    w_vga_r_d = rep4((hpos[2:0] == 3'd0) | (vpos[2:0] == 3'd0));
                    w_vga_g_d = rep4(vpos[4]);
                    w_vga_b_d = rep4(hpos[4]);
                end
                PAT_BARS: begin
                    w_vga_r_d = rep4(hpos[9]);
                    w_vga_g_d = rep4(hpos[8]);
                    w_vga_b_d = rep4(hpos[7]);
                end
                PAT_WHITE: begin
                    w_vga_r_d = 4'hF;
                    w_vga_g_d = 4'hF;
                    w_vga_b_d = 4'hF;
                end
                PAT_RAMP: begin
                    w_vga_r_d = hpos[9:6];
                    w_vga_g_d = hpos[9:6];
                    w_vga_b_d = hpos[9:6];
                end
                default: begin
                    w_vga_r_d = 4'h0;
                end
            endcase
        end
    end

    // Output pipeline stage keeping sync and colour aligned, plus pattern bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsync_prev_q  <= 1'b0;
            r_hsync_q       <= 1'b0;
            r_vsync_q       <= 1'b0;
            r_frame_start_q <= 1'b0;
            r_pattern_q     <= PAT_GRID;
            r_pending_q     <= 1'b0;
            r_vga_r_q       <= 4'h0;
            r_vga_g_q       <= 4'h0;
            r_vga_b_q       <= 4'h0;
        end else begin
            r_vsync_prev_q  <= vsync_in;
            r_hsync_q       <= hsync_in;
            r_vsync_q       <= vsync_in;
            r_frame_start_q <= w_frame_edge;
            r_pattern_q     <= w_pattern_d;
            r_pending_q     <= w_pending_d;
            r_vga_r_q       <= w_vga_r_d;
            r_vga_g_q       <= w_vga_g_d;
            r_vga_b_q       <= w_vga_b_d;
        end
    end

    // Position bits no pattern looks at.
    logic w_unused_bits;
    assign w_unused_bits = ^{hpos[5], hpos[3], vpos[9:5], vpos[3], 10'(H_ACTIVE), 10'(V_ACTIVE)};

    assign hsync       = r_hsync_q;
    assign vsync       = r_vsync_q;
    assign VGA_R       = r_vga_r_q;
    assign VGA_G       = r_vga_g_q;
    assign VGA_B       = r_vga_b_q;
    assign pattern_idx = r_pattern_q;
    assign auto_mode   = w_auto_mode;
    assign frame_start = r_frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_scheduler
// Description : Self-checking bench for pattern_scheduler with a scaled
//               vsync model, a table of colour vectors fed through a
//               scoreboard queue, and hand-written button/frame sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pattern_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync_in = 1'b0, vsync_in = 1'b0, display_on = 1'b0;
    logic [9:0] hpos = '0, vpos = '0;
    logic       btn_next = 1'b0, btn_mode = 1'b0;
    logic       hsync, vsync, auto_mode, frame_start;
    logic [3:0] VGA_R, VGA_G, VGA_B;
    logic [1:0] pattern_idx;

    int checks   = 0;
    int failures = 0;
    int exp_idx  = 0;

    typedef struct {
        logic [1:0] pat;
        logic       de;
        logic [9:0] h;
        logic [9:0] v;
        logic [3:0] r, g, b;
    } vec_t;

    typedef struct {
        logic       hs;
        logic       vs;
        logic [3:0] r, g, b;
    } exp_t;

    vec_t vecs[14];
    exp_t sb_q[$];

    pattern_scheduler #(
        .NUM_PATTERNS       (4),
        .FRAMES_PER_PATTERN (3),
        .DEBOUNCE_CYCLES    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .display_on  (display_on),
        .hpos        (hpos),
        .vpos        (vpos),
        .btn_next    (btn_next),
        .btn_mode    (btn_mode),
        .hsync       (hsync),
        .vsync       (vsync),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .pattern_idx (pattern_idx),
        .auto_mode   (auto_mode),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scaled frame: a short low stretch then a 2-cycle vsync pulse.
    task automatic do_frame();
        repeat (4) tick();
        vsync_in = 1'b1;
        tick();
        check("frame_start_pulse", 32'(frame_start), 32'd1);
        tick();
        vsync_in = 1'b0;
        tick();
    endtask

    // Hold a button for n cycles, then let the debouncer settle.
    task automatic press(input bit is_mode, input int n);
        if (is_mode) btn_mode = 1'b1;
        else         btn_next = 1'b1;
        repeat (n) tick();
        btn_mode = 1'b0;
        btn_next = 1'b0;
        repeat (8) tick();
    endtask

    task automatic advance();
        press(1'b0, 6);
        do_frame();
        exp_idx = (exp_idx + 1) % 4;
    endtask

    // Drive one pixel, queue its expectation, and compare once the DUT registers it.
    task automatic apply_pixel(input int i);
        exp_t e;
        exp_t got_e;
        display_on = vecs[i].de;
        hpos       = vecs[i].h;
        vpos       = vecs[i].v;
        hsync_in   = 1'($urandom_range(0, 1));
        e.hs = hsync_in;
        e.vs = 1'b0;
        e.r  = vecs[i].r;
        e.g  = vecs[i].g;
        e.b  = vecs[i].b;
        sb_q.push_back(e);
        tick();
        got_e = sb_q.pop_front();
        check($sformatf("pix[%0d]", i),
              32'({hsync, vsync, VGA_R, VGA_G, VGA_B}),
              32'({got_e.hs, got_e.vs, got_e.r, got_e.g, got_e.b}));
    endtask

    initial begin
        // pattern, display_on, hpos, vpos, expected R/G/B
        vecs[0]  = '{2'd0, 1'b1, 10'd0,   10'd5,  4'hF, 4'h0, 4'h0};
        vecs[1]  = '{2'd0, 1'b1, 10'd17,  10'd19, 4'h0, 4'hF, 4'hF};
        vecs[2]  = '{2'd0, 1'b1, 10'd21,  10'd40, 4'hF, 4'h0, 4'hF};
        vecs[3]  = '{2'd0, 1'b0, 10'd0,   10'd0,  4'h0, 4'h0, 4'h0};
        // hpos 300 falls in bar 2 (3'b010): green only
        vecs[4]  = '{2'd1, 1'b1, 10'd300, 10'd10, 4'h0, 4'hF, 4'h0};
        vecs[5]  = '{2'd1, 1'b1, 10'd639, 10'd10, 4'hF, 4'h0, 4'h0};
        vecs[6]  = '{2'd1, 1'b1, 10'd128, 10'd10, 4'h0, 4'h0, 4'hF};
        vecs[7]  = '{2'd1, 1'b0, 10'd300, 10'd10, 4'h0, 4'h0, 4'h0};
        vecs[8]  = '{2'd2, 1'b1, 10'd5,   10'd5,  4'hF, 4'hF, 4'hF};
        vecs[9]  = '{2'd2, 1'b0, 10'd5,   10'd5,  4'h0, 4'h0, 4'h0};
        vecs[10] = '{2'd3, 1'b1, 10'd300, 10'd0,  4'h4, 4'h4, 4'h4};
        vecs[11] = '{2'd3, 1'b1, 10'd639, 10'd0,  4'h9, 4'h9, 4'h9};
        vecs[12] = '{2'd3, 1'b1, 10'd0,   10'd0,  4'h0, 4'h0, 4'h0};
        vecs[13] = '{2'd3, 1'b0, 10'd639, 10'd0,  4'h0, 4'h0, 4'h0};

        // Reset for 3 cycles with live-looking inputs; outputs must stay 0.
        reset      = 1'b1;
        display_on = 1'b1;
        hsync_in   = 1'b1;
        repeat (3) tick();
        check("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd0);
        display_on = 1'b0;
        hsync_in   = 1'b0;
        reset      = 1'b0;
        tick();
        check("post_rst_idx", 32'(pattern_idx), 32'd0);
`ifdef AUTO_CYCLE_EN
        check("post_rst_auto", 32'(auto_mode), 32'd1);
`else
        check("post_rst_auto", 32'(auto_mode), 32'd0);
`endif
        check("post_rst_out", 32'({hsync, vsync, frame_start, VGA_R, VGA_G, VGA_B}), 32'd0);

`ifdef AUTO_CYCLE_EN
        // AUTO: advances at frame_starts 3 and 6 only.
        for (int f = 1; f <= 7; f++) begin
            do_frame();
            if (f % 3 == 0) exp_idx = (exp_idx + 1) % 4;
            check($sformatf("auto_frame%0d_idx", f), 32'(pattern_idx), 32'(exp_idx));
        end
`endif
        // Mode press: MANUAL (or ignored when AUTO is compiled out).
        press(1'b1, 6);
        check("mode_auto", 32'(auto_mode), 32'd0);
        do_frame();
        check("frame_start_clear", 32'(frame_start), 32'd0);
        check("manual_hold_idx", 32'(pattern_idx), 32'(exp_idx));

        // Two requests in one frame collapse into one advance.
        press(1'b0, 6);
        press(1'b0, 6);
        check("no_midframe_commit", 32'(pattern_idx), 32'(exp_idx));
        do_frame();
        exp_idx = (exp_idx + 1) % 4;
        check("double_req_idx", 32'(pattern_idx), 32'(exp_idx));
        do_frame();
        check("no_leftover_pending", 32'(pattern_idx), 32'(exp_idx));

        // Short glitch rejected; a long hold accepted once.
        press(1'b0, 2);
        do_frame();
        check("glitch_idx", 32'(pattern_idx), 32'(exp_idx));
        press(1'b0, 6);
        do_frame();
        exp_idx = (exp_idx + 1) % 4;
        check("held_idx", 32'(pattern_idx), 32'(exp_idx));

        // Colour vectors per pattern through the scoreboard.
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < 4 && exp_idx != int'(vecs[i].pat); k++) begin
                display_on = 1'b0;
                advance();
                check("table_adv_idx", 32'(pattern_idx), 32'(exp_idx));
            end
            apply_pixel(i);
        end
        display_on = 1'b0;
        hsync_in   = 1'b0;

        // Wrap from the last pattern back to GRID.
        advance();
        check("wrap_idx", 32'(pattern_idx), 32'd0);

        // Reset mid-line while showing WHITE.
        advance();
        advance();
        check("pre_reset_idx", 32'(pattern_idx), 32'd2);
        display_on = 1'b1;
        hpos       = 10'd100;
        tick();
        check("white_live", 32'(VGA_R), 32'hF);
        reset = 1'b1;
        tick();
        check("midline_rst_idx", 32'(pattern_idx), 32'd0);
        check("midline_rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        reset      = 1'b0;
        display_on = 1'b0;
        tick();
        check("post_midline_blank", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        display_on = 1'b1;
        hpos       = 10'd0;
        vpos       = 10'd0;
        tick();
        check("post_midline_grid", 32'({VGA_R, VGA_G, VGA_B}), 32'hF00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
